master_spi4nano: RTL and testbench
==================================

# master_spi4nano

SPI master that drives the Nano system's programming port (SPI_CS, SPI_SCK, SPI_MOSI, SPI_MISO) from a host-side or test-side controller. Each `start` request becomes one fixed 40-bit frame: command, address, write data. It captures the slave's 16-bit reply and signals completion with a one-cycle `done` pulse. It is the initiator counterpart of the on-chip SPI slave and runs on the same CLK. Intended use: self-test harnesses, board-level loader FPGAs, and loop-back verification of the programming path.

## Interface
Parameters:
- SCK_HALF, 4: CLK cycles per SCK half-period; must be ≥1. The value 4 gives f_SCK = 195.3125 kHz at f_CLK = 1.5625 MHz.
- FRAME_BITS, 40: frame length in bits; fixed at 8+16+16, not to be overridden.

Ports (one clock; reset is asynchronous and active-low):
- CLK  in  1  system clock, rising-edge.
- NRST  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- cmd  in  8  frame command byte; latched at accept.
- add  in  16  frame address; latched at accept.
- wdata  in  16  frame write data; latched at accept.
- busy  out  1  high from the cycle after accept until `done`.
- done  out  1  one-cycle completion pulse.
- rdata  out  16  last 16 MISO bits of the most recent completed frame.
- SPI_CS  out  1  chip select, active low.
- SPI_SCK  out  1  serial clock, SPI mode 0 (idle low).
- SPI_MOSI  out  1  serial data to slave, MSB first.
- SPI_MISO  in  1  serial data from slave.

## Operation
- Reset values: SPI_CS=1, SPI_SCK=0, SPI_MOSI=0, busy=0, done=0, rdata=0. Internal state is IDLE.
- Frame shift register = {cmd, add, wdata}. Bit 39 is sent first.
- State machine: IDLE → SETUP → SHIFT_LO ⇄ SHIFT_HI → HOLD → GAP → IDLE.
- IDLE:
  - start=1 latches cmd, add and wdata.
  - Next state is SETUP.
  - busy rises on the next cycle.
- SETUP (SCK_HALF cycles):
  - SPI_CS=0, SPI_SCK=0.
  - SPI_MOSI = bit 39.
- SHIFT_HI (SCK_HALF cycles):
  - SPI_SCK=1.
  - SPI_MISO is sampled on the last CLK cycle of the phase and shifted into the capture register.
- SHIFT_LO (SCK_HALF cycles, entered after each SHIFT_HI):
  - SPI_SCK=0.
  - SPI_MOSI advances to the next bit.
  - After the 40th SHIFT_HI, go to HOLD instead.
- HOLD (SCK_HALF cycles): SPI_CS=0, SPI_SCK=0.
- GAP (SCK_HALF cycles):
  - SPI_CS=1, SPI_MOSI=0.
  - On exit: done=1 for one cycle, busy=0 in the same cycle.
  - rdata is loaded with capture bits [15:0].
- rdata holds its value until the next `done`.
- start while busy is ignored; no queueing.
- start asserted in the same cycle as `done` is ignored. The first accept is possible on the cycle after `done`.
- The block does not interpret `cmd`. Command encodings belong to the slave protocol definition in the shared package.

## Timing
- Accept edge = t0. SPI_CS falls and busy rises at t0+1.
- Frame length:
  - Rising SCK edges: 40.
  - Last SCK fall: t0+1+SCK_HALF·81.
  - SPI_CS rises: t0+1+SCK_HALF·82.
  - done: t0+1+SCK_HALF·83, i.e. t0+333 for SCK_HALF=4.
- MOSI changes only while SCK=0. It is stable for ≥SCK_HALF cycles before and after every rising SCK.
- MISO sample point: SCK_HALF−1 CLK cycles after SCK rises. This tolerates a slave that updates MISO on the falling edge.
- NRST low mid-frame:
  - SPI_CS=1 and SPI_SCK=0 immediately (asynchronous).
  - No done is issued; rdata returns to 0.
- SCK_HALF=1 must work. In that case SCK = CLK/2.

## Structure
- Package nano_spi_pkg holds:
  - Frame field widths (CMD_W=8, ADD_W=16, DAT_W=16, FRAME_BITS=40).
  - The state enum.
  - Command constants shared with the slave.
- One sub-module, spi_sck_timer:
  - Half-period down-counter, width $clog2(SCK_HALF)+1.
  - Outputs: phase_end pulse and bit-count terminal flag.
- The top level contains the FSM and the 40-bit shift/capture registers.

## Test plan
- Reset: hold NRST=0 → SPI_CS=1, SPI_SCK=0, SPI_MOSI=0, busy=0, rdata=0x0000.
- Basic frame, SCK_HALF=4: start with cmd=0xA5, add=0x0123, wdata=0xBEEF → slave model receives bit stream 0xA50123BEEF over exactly 40 SCK rises; done at t0+333.
- Read-back: slave model drives 0x5AC3 on the final 16 bits (0x12 on the first 24) → rdata=0x5AC3 after done, held until the next done.
- start while busy, pulsed at t0+10 and t0+200 → no effect; exactly one frame and one done. start asserted in the done cycle → ignored; next-cycle start → accepted.
- Mid-frame reset: NRST low at t0+100 → SPI_CS=1 asynchronously, no done pulse; a subsequent frame with cmd=0x3C, add=0x0000, wdata=0xFFFF is correct.
- SCK_HALF=1 build: same frame as the basic-frame scenario → SCK period of 2 CLK; done at t0+84; bit stream matches.

Source files
------------

// File: rtl/nano_spi_pkg.sv
// Shared definitions for the Nano programming-port SPI: frame layout, master
// FSM encoding and the command bytes understood by the on-chip slave.
package nano_spi_pkg;

  localparam int CMD_W      = 8;
  localparam int ADD_W      = 16;
  localparam int DAT_W      = 16;
  localparam int FRAME_BITS = CMD_W + ADD_W + DAT_W;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SETUP    = 3'd1;
  localparam logic [2:0] ST_SHIFT_LO = 3'd2;
  localparam logic [2:0] ST_SHIFT_HI = 3'd3;
  localparam logic [2:0] ST_HOLD     = 3'd4;
  localparam logic [2:0] ST_GAP      = 3'd5;

  localparam logic [CMD_W-1:0] CMD_NOP    = 8'h00;
  localparam logic [CMD_W-1:0] CMD_WRITE  = 8'h02;
  localparam logic [CMD_W-1:0] CMD_READ   = 8'h03;
  localparam logic [CMD_W-1:0] CMD_STATUS = 8'h05;

  function automatic logic [FRAME_BITS-1:0] pack_frame(
    input logic [CMD_W-1:0] c,
    input logic [ADD_W-1:0] a,
    input logic [DAT_W-1:0] d
  );
    return {c, a, d};
  endfunction

endpackage

// File: rtl/master_spi4nano_sck_timer.sv
// SCK half-period timer plus frame bit counter for the Nano SPI master.
// Both count down; the FSM holds restart high while idle so every frame starts aligned.
module spi_sck_timer #(
  parameter int SCK_HALF   = 4,
  parameter int FRAME_BITS = 40
) (
  input  logic CLK,
  input  logic NRST,
  input  logic restart,
  input  logic bit_step,
  output logic phase_end,
  output logic bit_last
);

  localparam int CNT_W = $clog2(SCK_HALF) + 1;
  localparam int BIT_W = $clog2(FRAME_BITS);

  logic [CNT_W-1:0] half_cnt;
  logic [BIT_W-1:0] bit_cnt;

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      half_cnt <= CNT_W'(SCK_HALF - 1);
      bit_cnt  <= BIT_W'(FRAME_BITS - 1);
    end else begin
      if (restart || phase_end) half_cnt <= CNT_W'(SCK_HALF - 1);
      else                      half_cnt <= half_cnt - 1'b1;

      if (restart)       bit_cnt <= BIT_W'(FRAME_BITS - 1);
      else if (bit_step) bit_cnt <= bit_cnt - 1'b1;
    end
  end

  assign phase_end = (half_cnt == '0);
  assign bit_last  = (bit_cnt == '0);

endmodule

// File: rtl/master_spi4nano.sv
// SPI mode-0 master driving the Nano programming port with one 40-bit frame per start.
//   state    | meaning
//   IDLE     | waiting for start, CS high
//   SETUP    | CS low, first bit on MOSI
//   SHIFT_LO | SCK low, MOSI presents current bit
//   SHIFT_HI | SCK high, MISO sampled on last cycle, register shifts
//   HOLD     | CS still low after the last SCK fall
//   GAP      | CS high before done
module master_spi4nano #(
  parameter int SCK_HALF   = 4,
  parameter int FRAME_BITS = nano_spi_pkg::FRAME_BITS
) (
  input  logic                           CLK,
  input  logic                           NRST,
  input  logic                           start,
  input  logic [nano_spi_pkg::CMD_W-1:0] cmd,
  input  logic [nano_spi_pkg::ADD_W-1:0] add,
  input  logic [nano_spi_pkg::DAT_W-1:0] wdata,
  output logic                           busy,
  output logic                           done,
  output logic [nano_spi_pkg::DAT_W-1:0] rdata,
  output logic                           SPI_CS,
  output logic                           SPI_SCK,
  output logic                           SPI_MOSI,
  input  logic                           SPI_MISO
);
  import nano_spi_pkg::*;

  logic [2:0]            state, state_nx;
  logic [FRAME_BITS-1:0] sreg;
  logic                  phase_end, bit_last, accept, fin_q, hi_end;

  // busy/done gate the accept so a start in the done cycle is dropped
  assign accept = (state == ST_IDLE) && start && !busy && !done;
  assign hi_end = (state == ST_SHIFT_HI) && phase_end;

  spi_sck_timer #(
    .SCK_HALF  (SCK_HALF),
    .FRAME_BITS(FRAME_BITS)
  ) u_timer (
    .CLK      (CLK),
    .NRST     (NRST),
    .restart  (state == ST_IDLE),
    .bit_step (hi_end),
    .phase_end(phase_end),
    .bit_last (bit_last)
  );

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:     if (accept)    state_nx = ST_SETUP;
      ST_SETUP:    if (phase_end) state_nx = ST_SHIFT_LO;
      ST_SHIFT_LO: if (phase_end) state_nx = ST_SHIFT_HI;
      ST_SHIFT_HI: if (phase_end) state_nx = bit_last ? ST_HOLD : ST_SHIFT_LO;
      ST_HOLD:     if (phase_end) state_nx = ST_GAP;
      ST_GAP:      if (phase_end) state_nx = ST_IDLE;
      default:                    state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // One register shifts the frame out and the reply in, so it ends holding the MISO bits
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST)       sreg <= '0;
    else if (accept) sreg <= pack_frame(cmd, add, wdata);
    else if (hi_end) sreg <= {sreg[FRAME_BITS-2:0], SPI_MISO};
  end

  // Pins are registered from the state, which puts every edge one CLK after the FSM
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      SPI_CS   <= 1'b1;
      SPI_SCK  <= 1'b0;
      SPI_MOSI <= 1'b0;
      busy     <= 1'b0;
      fin_q    <= 1'b0;
      done     <= 1'b0;
      rdata    <= '0;
    end else begin
      SPI_CS   <= !(state inside {ST_SETUP, ST_SHIFT_LO, ST_SHIFT_HI, ST_HOLD});
      SPI_SCK  <= (state == ST_SHIFT_HI);
      SPI_MOSI <= (state inside {ST_SETUP, ST_SHIFT_LO, ST_SHIFT_HI}) ? sreg[FRAME_BITS-1] : 1'b0;
      busy     <= (state != ST_IDLE);
      fin_q    <= (state == ST_GAP) && phase_end;
      done     <= fin_q;
      if (fin_q) rdata <= sreg[DAT_W-1:0];
    end
  end

endmodule

// File: tb/tb_master_spi4nano.sv
// Bench for master_spi4nano: one DUT with SCK_HALF=4 and one with SCK_HALF=1,
// each attached to a mode-0 slave model; frames checked against spec-level expectations.
module tb_master_spi4nano;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        nrst;
  logic [7:0]  cmd;
  logic [15:0] add, wdata;
  logic        start0, start1;
  logic        busy0, busy1, done0, done1;
  logic [15:0] rdata0, rdata1;
  logic        cs0, cs1, sck0, sck1, mosi0, mosi1, miso0, miso1;

  master_spi4nano #(.SCK_HALF(4)) dut_h4 (
    .CLK(CLK), .NRST(nrst), .start(start0), .cmd(cmd), .add(add), .wdata(wdata),
    .busy(busy0), .done(done0), .rdata(rdata0),
    .SPI_CS(cs0), .SPI_SCK(sck0), .SPI_MOSI(mosi0), .SPI_MISO(miso0)
  );

  master_spi4nano #(.SCK_HALF(1)) dut_h1 (
    .CLK(CLK), .NRST(nrst), .start(start1), .cmd(cmd), .add(add), .wdata(wdata),
    .busy(busy1), .done(done1), .rdata(rdata1),
    .SPI_CS(cs1), .SPI_SCK(sck1), .SPI_MOSI(mosi1), .SPI_MISO(miso1)
  );

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Slave models: capture MOSI on rising SCK, advance MISO on falling SCK
  logic [39:0] rx0 = '0, rx1 = '0, tx0 = '0, tx1 = '0;
  int rises0 = 0, rises1 = 0, falls0 = 0, falls1 = 0;
  int rbase0 = 0, rbase1 = 0, fbase0 = 0, fbase1 = 0;

  always @(posedge sck0) begin rx0 = {rx0[38:0], mosi0}; rises0++; end
  always @(posedge sck1) begin rx1 = {rx1[38:0], mosi1}; rises1++; end
  always @(negedge sck0) falls0++;
  always @(negedge sck1) falls1++;

  function automatic logic slave_bit(input logic [39:0] p, input int k);
    if (k < 0 || k > 39) return 1'b0;
    return p[39-k];
  endfunction

  assign miso0 = slave_bit(tx0, falls0 - fbase0);
  assign miso1 = slave_bit(tx1, falls1 - fbase1);

  // Reference model: what the slave must see and what the master must report
  function automatic logic [39:0] ref_stream(input logic [7:0] c, input logic [15:0] a, input logic [15:0] w);
    return {c, a, w};
  endfunction
  function automatic logic [15:0] ref_rdata(input logic [39:0] reply);
    return reply[15:0];
  endfunction
  function automatic int ref_latency(input int d);
    return 1 + 83 * ((d == 0) ? 4 : 1);
  endfunction

  function automatic logic o_cs(input int d);   return (d == 0) ? cs0 : cs1;     endfunction
  function automatic logic o_busy(input int d); return (d == 0) ? busy0 : busy1; endfunction
  function automatic logic o_done(input int d); return (d == 0) ? done0 : done1; endfunction
  function automatic logic [15:0] o_rdata(input int d); return (d == 0) ? rdata0 : rdata1; endfunction

  int n_checks = 0;
  int n_pass   = 0;
  int t0c      = 0;
  logic [15:0] last_r0 = '0, last_r1 = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic set_start(input int d, input logic v);
    if (d == 0) start0 = v;
    else        start1 = v;
  endtask

  // Called at a negedge; start is sampled at the next posedge (t0)
  task automatic launch(input int d, input logic [39:0] reply);
    if (d == 0) begin tx0 = reply; fbase0 = falls0; rbase0 = rises0; end
    else        begin tx1 = reply; fbase1 = falls1; rbase1 = rises1; end
    set_start(d, 1'b1);
    @(posedge CLK);
    @(negedge CLK);
    t0c = cyc;
    set_start(d, 1'b0);
    chk("cs_high_at_t0", o_cs(d), 1);
    chk("busy_low_at_t0", o_busy(d), 0);
    @(negedge CLK);
    chk("cs_low_at_t0p1", o_cs(d), 0);
    chk("busy_high_at_t0p1", o_busy(d), 1);
  endtask

  // Returns at the negedge of the done cycle
  task automatic finish(input int d, input logic [39:0] exp_stream, input logic [15:0] exp_rd, input bit pulse_busy);
    bit got;
    int rel;
    got = 0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge CLK);
      rel = cyc - t0c;
      if (pulse_busy) set_start(d, (rel == 10 || rel == 200));
      if (rel == 100) chk("rdata_hold", o_rdata(d), (d == 0) ? last_r0 : last_r1);
      if (o_done(d)) begin got = 1; break; end
    end
    set_start(d, 1'b0);
    chk("done_seen", got, 1);
    if (got) begin
      chk("done_latency", cyc - t0c, ref_latency(d));
      chk("sck_rises", (d == 0) ? rises0 - rbase0 : rises1 - rbase1, 40);
      chk("mosi_stream", (d == 0) ? rx0 : rx1, exp_stream);
      chk("rdata", o_rdata(d), exp_rd);
      chk("busy_low_in_done", o_busy(d), 0);
      chk("cs_high_in_done", o_cs(d), 1);
      if (d == 0) last_r0 = exp_rd;
      else        last_r1 = exp_rd;
    end
  endtask

  task automatic after_done(input int d, input logic [15:0] exp_rd);
    @(negedge CLK);
    chk("done_one_cycle", o_done(d), 0);
    chk("rdata_after_done", o_rdata(d), exp_rd);
  endtask

  task automatic quiet(input int d, input int n);
    int extra;
    extra = 0;
    repeat (n) begin
      @(negedge CLK);
      if (o_done(d)) extra++;
    end
    chk("no_extra_done", extra, 0);
    chk("idle_busy_low", o_busy(d), 0);
  endtask

  typedef struct {
    logic [7:0]  cmd;
    logic [15:0] add;
    logic [15:0] wdata;
    logic [39:0] reply;
    int          dut;
    logic [39:0] exp_stream;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [39:0] rp;
    tbl[0] = '{8'hA5, 16'h0123, 16'hBEEF, 40'h121212_5AC3, 0, 40'hA5_0123_BEEF, 16'h5AC3};
    tbl[1] = '{8'hA5, 16'h0123, 16'hBEEF, 40'h121212_5AC3, 1, 40'hA5_0123_BEEF, 16'h5AC3};
    for (int i = 2; i < 10; i++) begin
      tbl[i].cmd        = 8'($urandom);
      tbl[i].add        = 16'($urandom);
      tbl[i].wdata      = 16'($urandom);
      tbl[i].reply      = {8'($urandom), 32'($urandom)};
      tbl[i].dut        = i % 2;
      tbl[i].exp_stream = ref_stream(tbl[i].cmd, tbl[i].add, tbl[i].wdata);
      tbl[i].exp_rdata  = ref_rdata(tbl[i].reply);
    end

    nrst = 1'b0; start0 = 1'b0; start1 = 1'b0;
    cmd = '0; add = '0; wdata = '0;
    repeat (3) @(negedge CLK);
    for (int d = 0; d < 2; d++) begin
      chk("rst_cs", o_cs(d), 1);
      chk("rst_sck", (d == 0) ? sck0 : sck1, 0);
      chk("rst_mosi", (d == 0) ? mosi0 : mosi1, 0);
      chk("rst_busy", o_busy(d), 0);
      chk("rst_done", o_done(d), 0);
      chk("rst_rdata", o_rdata(d), 16'h0000);
    end
    nrst = 1'b1;
    repeat (2) @(negedge CLK);

    for (int i = 0; i < 10; i++) begin
      cmd = tbl[i].cmd; add = tbl[i].add; wdata = tbl[i].wdata;
      launch(tbl[i].dut, tbl[i].reply);
      finish(tbl[i].dut, tbl[i].exp_stream, tbl[i].exp_rdata, 1'b0);
      after_done(tbl[i].dut, tbl[i].exp_rdata);
      repeat (3) @(negedge CLK);
    end

    // rdata stays put while idle
    repeat (50) @(negedge CLK);
    chk("rdata_idle_hold", rdata0, last_r0);

    // start pulses while busy are dropped, nothing queued afterwards
    cmd = 8'hA5; add = 16'h0123; wdata = 16'hBEEF;
    launch(0, 40'h121212_5AC3);
    finish(0, 40'hA5_0123_BEEF, 16'h5AC3, 1'b1);
    quiet(0, 400);

    // start in the done cycle is ignored, start in the next cycle is accepted
    cmd = 8'h03; add = 16'h4455; wdata = 16'h6677;
    launch(0, 40'h00_0000_1234);
    finish(0, 40'h03_4455_6677, 16'h1234, 1'b0);
    start0 = 1'b1;
    @(negedge CLK);
    chk("dc_done_low", done0, 0);
    chk("dc_busy_low", busy0, 0);
    cmd = 8'h02; add = 16'h8001; wdata = 16'h0F0F;
    launch(0, 40'hFF_FFFF_A55A);
    finish(0, 40'h02_8001_0F0F, 16'hA55A, 1'b0);
    after_done(0, 16'hA55A);

    // asynchronous reset in the middle of a frame, while SCK is high
    cmd = 8'hC3; add = 16'h1111; wdata = 16'h2222;
    launch(0, 40'h12_3456_789A);
    repeat (98) @(negedge CLK);
    for (int i = 0; i < 20 && !sck0; i++) @(negedge CLK);
    chk("sck_high_before_rst", sck0, 1);
    chk("cs_low_before_rst", cs0, 0);
    #2 nrst = 1'b0;
    #1;
    chk("arst_cs", cs0, 1);
    chk("arst_sck", sck0, 0);
    chk("arst_busy", busy0, 0);
    chk("arst_rdata", rdata0, 16'h0000);
    repeat (3) @(negedge CLK);
    nrst = 1'b1;
    last_r0 = '0;
    last_r1 = '0;
    quiet(0, 400);

    rp = {8'h55, 32'($urandom)};
    cmd = 8'h3C; add = 16'h0000; wdata = 16'hFFFF;
    launch(0, rp);
    finish(0, ref_stream(8'h3C, 16'h0000, 16'hFFFF), ref_rdata(rp), 1'b0);
    after_done(0, ref_rdata(rp));

    // SCK_HALF=1 instance after the shared reset
    cmd = 8'hA5; add = 16'h0123; wdata = 16'hBEEF;
    launch(1, 40'h121212_5AC3);
    finish(1, 40'hA5_0123_BEEF, 16'h5AC3, 1'b0);
    after_done(1, 16'h5AC3);

    repeat (5) @(negedge CLK);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
